// File: rtl/ifu.sv
// Instruction fetch unit: holds the fetch PC, issues one memory read at a time,
// and hands each instruction with its PC to the decoder through a one-entry buffer.
module ifu #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(64'h8000_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [INST_WIDTH-1:0] mem_rsp_data,
    input  logic                  mem_rsp_err,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_fault
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HALT = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic                    inst_valid_q, inst_valid_d;
    logic [INST_WIDTH-1:0]   inst_q, inst_d;
    logic [ADDR_WIDTH-1:0]   inst_pc_q, inst_pc_d;
    logic                    inst_fault_q, inst_fault_d;

    logic                    aligned;
    logic                    req_hs;

    // Request depends only on registered state, never on inputs.
    assign aligned       = (fetch_pc_q[1:0] == 2'b00);
    assign mem_req_valid = (state_q == S_REQ) && !inst_valid_q && aligned;
    assign mem_req_addr  = fetch_pc_q;
    assign req_hs        = mem_req_valid && mem_req_ready;

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = inst_fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            fetch_pc_q   <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;

        if (inst_valid_q && inst_ready) begin
            inst_valid_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                // A misaligned PC becomes a fault marker once the buffer is free.
                if (!aligned) begin
                    if (!inst_valid_q) begin
                        inst_valid_d = 1'b1;
                        inst_d       = '0;
                        inst_pc_d    = fetch_pc_q;
                        inst_fault_d = 1'b1;
                        state_d      = S_HALT;
                    end
                end else if (req_hs) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    inst_valid_d = 1'b1;
                    inst_d       = mem_rsp_data;
                    inst_pc_d    = fetch_pc_q;
                    inst_fault_d = mem_rsp_err;
                    if (mem_rsp_err) begin
                        state_d = S_HALT;
                    end else begin
                        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
                        state_d    = S_REQ;
                    end
                end
            end
            S_DROP: begin
                if (mem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // Redirect overrides everything; a request still in flight must be drained.
        if (redirect_valid) begin
            fetch_pc_d   = redirect_pc;
            inst_valid_d = 1'b0;
            if (((state_q == S_WAIT) && !mem_rsp_valid) ||
                ((state_q == S_REQ) && req_hs)) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
            end
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: a one-outstanding memory model plus a scoreboard
// of expected {inst, pc, fault} entries compared on every decoder consumption.
module tb_ifu;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_fault;

    ifu dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_err    (mem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb[$];

    logic        req_ready_cfg = 1'b0;
    int          rsp_delay     = 1;
    logic [63:0] err_addr      = 64'h1;
    logic        pend          = 1'b0;
    logic [63:0] pend_addr     = '0;
    int          pend_cnt      = 0;
    logic        last_hs       = 1'b0;
    logic [63:0] last_hs_addr  = '0;
    int          n_req         = 0;
    int          cyc_no        = 0;
    logic        gap_en        = 1'b0;
    logic        cons_seen     = 1'b0;
    int          last_cons     = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h8000_0013;
    endfunction

    function automatic exp_t mk(input logic [63:0] pc, input logic fault);
        exp_t e;
        e.inst  = mem_word(pc);
        e.pc    = pc;
        e.fault = fault;
        return e;
    endfunction

    // One clock: drive memory, observe consumption/handshake, advance to next negedge.
    task automatic cyc();
        exp_t e;
        if (pend && pend_cnt == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(pend_addr);
            mem_rsp_err   = (pend_addr == err_addr);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
            mem_rsp_err   = 1'b0;
        end
        mem_req_ready = req_ready_cfg;

        if (inst_valid && inst_ready && !redirect_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_inst got pc=%h inst=%h fault=%b want none", inst_pc, inst, inst_fault);
            end else begin
                e = sb.pop_front();
                if (inst !== e.inst || inst_pc !== e.pc || inst_fault !== e.fault) begin
                    bad++;
                    $display("FAIL inst_out got pc=%h inst=%h fault=%b want pc=%h inst=%h fault=%b",
                             inst_pc, inst, inst_fault, e.pc, e.inst, e.fault);
                end
            end
            if (gap_en && cons_seen) begin
                total++;
                if (cyc_no - last_cons != 3) begin
                    bad++;
                    $display("FAIL throughput_gap got %0d want 3", cyc_no - last_cons);
                end
            end
            cons_seen = 1'b1;
            last_cons = cyc_no;
        end

        last_hs = mem_req_valid && mem_req_ready;
        if (mem_rsp_valid) pend = 1'b0;
        else if (pend) pend_cnt--;
        if (last_hs) begin
            total++;
            if (pend) begin
                bad++;
                $display("FAIL one_outstanding got second req addr=%h want none", mem_req_addr);
            end
            pend         = 1'b1;
            pend_addr    = mem_req_addr;
            last_hs_addr = mem_req_addr;
            pend_cnt     = rsp_delay - 1;
            n_req++;
        end
        cyc_no++;
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        cyc();
        redirect_valid = 1'b0;
    endtask

    task automatic run_until_empty(input int budget);
        int n = 0;
        inst_ready = 1'b1;
        while (sb.size() > 0 && n < budget) begin
            cyc();
            n++;
        end
        inst_ready = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_hs(input int budget);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!last_hs && n < budget);
        total++;
        if (!last_hs) begin
            bad++;
            $display("FAIL hs_timeout got no request want request");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        mem_rsp_err    = 1'b0;
        inst_ready     = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 64'h0 || inst_fault !== 1'b0) begin
            bad++;
            $display("FAIL reset_buffer got v=%b inst=%h pc=%h f=%b want 0/0/0/0", inst_valid, inst, inst_pc, inst_fault);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0000) begin
            bad++;
            $display("FAIL reset_req got v=%b addr=%h want 1 80000000", mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_basic();
        req_ready_cfg = 1'b1;
        rsp_delay     = 1;
        inst_ready    = 1'b1;
        sb.push_back(mk(64'h8000_0000, 1'b0));
        sb.push_back(mk(64'h8000_0004, 1'b0));
        sb.push_back(mk(64'h8000_0008, 1'b0));
        cyc();
        total++;
        if (last_hs !== 1'b1 || last_hs_addr !== 64'h8000_0000) begin
            bad++;
            $display("FAIL first_req got hs=%b addr=%h want 1 80000000", last_hs, last_hs_addr);
        end
        cyc();
        total++;
        if (inst_valid !== 1'b1 || inst !== 32'h0000_0013 || inst_pc !== 64'h8000_0000) begin
            bad++;
            $display("FAIL first_inst got v=%b inst=%h pc=%h want 1 00000013 80000000", inst_valid, inst, inst_pc);
        end
        run_until_empty(40);
    endtask

    task automatic test_stall();
        int n = 0;
        req_ready_cfg = 1'b0;
        do_redirect(64'h8000_0200);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0200) begin
                bad++;
                $display("FAIL req_hold got v=%b addr=%h want 1 80000200", mem_req_valid, mem_req_addr);
            end
            cyc();
        end
        req_ready_cfg = 1'b1;
        while (!inst_valid && n < 20) begin
            cyc();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (inst_valid !== 1'b1 || inst !== mem_word(64'h8000_0200) ||
                inst_pc !== 64'h8000_0200 || mem_req_valid !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold got v=%b inst=%h pc=%h req=%b want 1 %h 80000200 0",
                         inst_valid, inst, inst_pc, mem_req_valid, mem_word(64'h8000_0200));
            end
            cyc();
        end
        sb.push_back(mk(64'h8000_0200, 1'b0));
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        total++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0204) begin
            bad++;
            $display("FAIL resume_req got v=%b addr=%h want 1 80000204", mem_req_valid, mem_req_addr);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL stall_consume got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_redirect_wait();
        rsp_delay = 3;
        do_redirect(64'h8000_0300);
        wait_hs(20);
        cyc();
        do_redirect(64'h8000_0100);
        rsp_delay = 1;
        sb.push_back(mk(64'h8000_0100, 1'b0));
        run_until_empty(30);
    endtask

    task automatic test_redirect_rsp();
        rsp_delay = 1;
        do_redirect(64'h8000_0400);
        wait_hs(20);
        do_redirect(64'h8000_0500);
        total++;
        if (inst_valid !== 1'b0) begin
            bad++;
            $display("FAIL rsp_dropped got inst_valid=%b want 0", inst_valid);
        end
        sb.push_back(mk(64'h8000_0500, 1'b0));
        run_until_empty(30);
    endtask

    task automatic test_redirect_hs();
        int n = 0;
        do_redirect(64'h8000_0600);
        while (!mem_req_valid && n < 20) begin
            cyc();
            n++;
        end
        do_redirect(64'h8000_0700);
        total++;
        if (mem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL drop_state got req_valid=%b want 0", mem_req_valid);
        end
        sb.push_back(mk(64'h8000_0700, 1'b0));
        run_until_empty(30);
    endtask

    task automatic test_err();
        int n0;
        err_addr = 64'h8000_0008;
        do_redirect(64'h8000_0000);
        sb.push_back(mk(64'h8000_0000, 1'b0));
        sb.push_back(mk(64'h8000_0004, 1'b0));
        sb.push_back(mk(64'h8000_0008, 1'b1));
        run_until_empty(40);
        n0 = n_req;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (mem_req_valid !== 1'b0) begin
                bad++;
                $display("FAIL halt_noreq got req_valid=%b want 0", mem_req_valid);
            end
            cyc();
        end
        total++;
        if (n_req != n0) begin
            bad++;
            $display("FAIL halt_count got %0d want %0d", n_req, n0);
        end
        err_addr = 64'h1;
    endtask

    task automatic test_misaligned();
        int n0;
        do_redirect(64'h8000_0002);
        n0 = n_req;
        sb.push_back('{inst: 32'h0, pc: 64'h8000_0002, fault: 1'b1});
        run_until_empty(20);
        for (int i = 0; i < 4; i++) cyc();
        total++;
        if (n_req != n0 || mem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL misaligned_noreq got reqs=%0d v=%b want %0d 0", n_req, mem_req_valid, n0);
        end
    endtask

    task automatic test_wrap();
        do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
        sb.push_back(mk(64'hFFFF_FFFF_FFFF_FFFC, 1'b0));
        sb.push_back(mk(64'h0, 1'b0));
        run_until_empty(30);
    endtask

    task automatic test_back_to_back();
        rsp_delay = 1;
        do_redirect(64'h8000_0800);
        for (int i = 0; i < 4; i++) sb.push_back(mk(64'h8000_0800 + 64'(4 * i), 1'b0));
        cons_seen = 1'b0;
        gap_en    = 1'b1;
        run_until_empty(40);
        gap_en    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_rsp();
        test_redirect_hs();
        test_err();
        test_misaligned();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
